// File: rtl/branch_hazard_stall_ctrl_if.sv
// ID-stage hazard interface: pipeline-side hazard inputs toward the controller,
// stall/flush controls and performance counters back.
interface branch_hazard_stall_ctrl_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
);
    logic                      ID_Branch;
    logic                      ID_Jump;
    logic                      ID_JumpReg;
    logic                      ID_UsesRs;
    logic                      ID_UsesRt;
    logic [REG_ADDR_WIDTH-1:0] ID_RegRs;
    logic [REG_ADDR_WIDTH-1:0] ID_RegRt;
    logic                      ID_BranchTaken;
    logic                      EX_RegWrite;
    logic                      EX_MemRead;
    logic [REG_ADDR_WIDTH-1:0] EX_RegWrAddr;
    logic                      MEM_MemRead;
    logic [REG_ADDR_WIDTH-1:0] MEM_RegWrAddr;
    logic                      Stall;
    logic                      ID_EX_Bubble;
    logic                      IF_ID_Flush;
    logic [CNT_WIDTH-1:0]      StallCycles;
    logic [CNT_WIDTH-1:0]      FlushCount;

    modport master (
        output ID_Branch, ID_Jump, ID_JumpReg, ID_UsesRs, ID_UsesRt, ID_RegRs, ID_RegRt,
               ID_BranchTaken, EX_RegWrite, EX_MemRead, EX_RegWrAddr, MEM_MemRead, MEM_RegWrAddr,
        input  Stall, ID_EX_Bubble, IF_ID_Flush, StallCycles, FlushCount
    );

    modport slave (
        input  ID_Branch, ID_Jump, ID_JumpReg, ID_UsesRs, ID_UsesRt, ID_RegRs, ID_RegRt,
               ID_BranchTaken, EX_RegWrite, EX_MemRead, EX_RegWrAddr, MEM_MemRead, MEM_RegWrAddr,
        output Stall, ID_EX_Bubble, IF_ID_Flush, StallCycles, FlushCount
    );
endinterface

// File: rtl/branch_hazard_stall_ctrl.sv
// ID-stage RAW hazard controller: stalls PC/IF-ID and bubbles ID/EX until a branch or
// load-use operand is forwardable, flushes IF/ID on taken control transfers, counts both.
module branch_hazard_stall_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input logic clk,
    input logic reset,
    branch_hazard_stall_ctrl_if.slave hz
);
    typedef enum logic {RUN, HOLD} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state;
    logic                 isBr;
    logic [1:0]           needRs, needRt, need;
    logic                 stall, flush;
    logic [CNT_WIDTH-1:0] stallCnt, flushCnt;

    // Cycles of stall one source operand still needs before the ID-stage forwarding covers it.
    function automatic logic [1:0] opNeed(
        input logic                      uses,
        input logic [REG_ADDR_WIDTH-1:0] r,
        input logic                      br,
        input logic                      exWr,
        input logic                      exLd,
        input logic [REG_ADDR_WIDTH-1:0] exAddr,
        input logic                      memLd,
        input logic [REG_ADDR_WIDTH-1:0] memAddr
    );
        logic       mEx, mMem;
        logic [1:0] n;
        mEx  = uses && exWr && (exAddr != '0) && (exAddr == r);
        mMem = uses && memLd && (memAddr != '0) && (memAddr == r);
        n    = 2'd0;
        if (br) begin
            if (mEx)       n = exLd ? 2'd2 : 2'd1;
            else if (mMem) n = 2'd1;
        end else if (exLd && mEx) begin
            n = 2'd1;
        end
        return n;
    endfunction

    assign isBr = hz.ID_Branch | hz.ID_JumpReg;

    always_comb begin
        needRs = opNeed(hz.ID_UsesRs, hz.ID_RegRs, isBr, hz.EX_RegWrite, hz.EX_MemRead,
                        hz.EX_RegWrAddr, hz.MEM_MemRead, hz.MEM_RegWrAddr);
        needRt = opNeed(hz.ID_UsesRt, hz.ID_RegRt, isBr, hz.EX_RegWrite, hz.EX_MemRead,
                        hz.EX_RegWrAddr, hz.MEM_MemRead, hz.MEM_RegWrAddr);
        need   = (needRs > needRt) ? needRs : needRt;
    end

    // Flush only once the branch has actually resolved, i.e. never in a stalled cycle.
    always_comb begin
        stall = 1'b0;
        flush = 1'b0;
        if (!reset) begin
            stall = (state == HOLD) || (need != 2'd0);
            flush = !stall && (hz.ID_Jump || (isBr && (hz.ID_JumpReg || hz.ID_BranchTaken)));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            case (state)
                RUN:     if (need == 2'd2) state <= HOLD;
                HOLD:    state <= RUN;
                default: state <= RUN;
            endcase
            if (stall && (stallCnt != '1)) stallCnt <= stallCnt + CNT_ONE;
            if (flush && (flushCnt != '1)) flushCnt <= flushCnt + CNT_ONE;
        end
    end

    assign hz.Stall        = stall;
    assign hz.ID_EX_Bubble = stall;
    assign hz.IF_ID_Flush  = flush;
    assign hz.StallCycles  = stallCnt;
    assign hz.FlushCount   = flushCnt;
endmodule

// File: tb/tb_branch_hazard_stall_ctrl.sv
// Directed bench: single-cycle vector table plus multi-cycle HOLD, reset and saturation sequences.
module tb_branch_hazard_stall_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   nChecks = 0;
    int   nPass = 0;

    always #5 clk = ~clk;

    branch_hazard_stall_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) bus ();
    branch_hazard_stall_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4))  bus4 ();

    branch_hazard_stall_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .hz(bus.slave));
    branch_hazard_stall_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .hz(bus4.slave));

    typedef struct {
        logic       br, jmp, jr, usesRs, usesRt;
        logic [4:0] rs, rt;
        logic       taken, exWr, exLd;
        logic [4:0] exAddr;
        logic       memLd;
        logic [4:0] memAddr;
        logic       expStall, expFlush;
    } vec_t;

    localparam vec_t ZV = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0,
                            5'd0, 1'b0, 5'd0, 1'b0, 1'b0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        else nPass++;
    endtask

    task automatic drive(input vec_t v);
        bus.ID_Branch      = v.br;
        bus.ID_Jump        = v.jmp;
        bus.ID_JumpReg     = v.jr;
        bus.ID_UsesRs      = v.usesRs;
        bus.ID_UsesRt      = v.usesRt;
        bus.ID_RegRs       = v.rs;
        bus.ID_RegRt       = v.rt;
        bus.ID_BranchTaken = v.taken;
        bus.EX_RegWrite    = v.exWr;
        bus.EX_MemRead     = v.exLd;
        bus.EX_RegWrAddr   = v.exAddr;
        bus.MEM_MemRead    = v.memLd;
        bus.MEM_RegWrAddr  = v.memAddr;
    endtask

    task automatic chkOut(input string name, input logic s, input logic f);
        chk({name, ".Stall"}, 32'(bus.Stall), 32'(s));
        chk({name, ".Bubble"}, 32'(bus.ID_EX_Bubble), 32'(s));
        chk({name, ".Flush"}, 32'(bus.IF_ID_Flush), 32'(f));
    endtask

    // Called at posedge+1; leaves at posedge+3 with the controller back in RUN, counters 0.
    task automatic resetDut();
        drive(ZV);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    vec_t tbl[13];
    vec_t v;
    int   expStallCnt, expFlushCnt;

    initial begin
        // rows: br jmp jr usesRs usesRt rs rt taken exWr exLd exAddr memLd memAddr | stall flush
        tbl[0]  = ZV;
        tbl[1]  = '{0,0,0,1,0, 5'd10,5'd0,  0, 1,0,5'd10, 0,5'd0,  0,0}; // sub in EX, non-branch
        tbl[2]  = '{0,0,0,1,0, 5'd10,5'd0,  0, 1,1,5'd10, 0,5'd0,  1,0}; // load-use
        tbl[3]  = '{0,0,0,0,0, 5'd0, 5'd10, 0, 1,1,5'd10, 0,5'd0,  0,0}; // rt not used
        tbl[4]  = '{1,0,0,1,0, 5'd9, 5'd0,  0, 1,0,5'd9,  0,5'd0,  1,0}; // branch on ALU in EX
        tbl[5]  = '{1,0,0,0,1, 5'd0, 5'd7,  0, 0,0,5'd0,  1,5'd7,  1,0}; // branch on load in MEM
        tbl[6]  = '{1,0,0,1,0, 5'd7, 5'd0,  1, 0,0,5'd0,  0,5'd7,  0,1}; // MEM not a load, taken
        tbl[7]  = '{1,0,0,1,1, 5'd3, 5'd4,  0, 0,0,5'd0,  0,5'd0,  0,0}; // not taken
        tbl[8]  = '{0,1,0,0,0, 5'd0, 5'd0,  0, 0,0,5'd0,  0,5'd0,  0,1}; // j
        tbl[9]  = '{0,0,1,1,0, 5'd0, 5'd0,  0, 1,1,5'd0,  0,5'd0,  0,1}; // jr $0 vs lw $0
        tbl[10] = '{1,0,0,1,0, 5'd5, 5'd0,  1, 0,0,5'd5,  0,5'd0,  0,1}; // EX not writing
        tbl[11] = '{1,0,0,1,0, 5'd6, 5'd0,  1, 1,0,5'd6,  0,5'd0,  1,0}; // stall beats taken
        tbl[12] = '{0,0,0,1,0, 5'd11,5'd0,  0, 0,0,5'd0,  1,5'd11, 0,0}; // MEM load, non-branch

        bus4.ID_Branch = 0; bus4.ID_Jump = 0; bus4.ID_JumpReg = 0; bus4.ID_UsesRs = 0;
        bus4.ID_UsesRt = 0; bus4.ID_RegRs = 0; bus4.ID_RegRt = 0; bus4.ID_BranchTaken = 0;
        bus4.EX_RegWrite = 0; bus4.EX_MemRead = 0; bus4.EX_RegWrAddr = 0;
        bus4.MEM_MemRead = 0; bus4.MEM_RegWrAddr = 0;

        // Reset state: hazard present but outputs held low
        v = ZV; v.br = 1; v.usesRs = 1; v.rs = 8; v.exWr = 1; v.exLd = 1; v.exAddr = 8;
        drive(v);
        @(negedge clk);
        chkOut("reset", 0, 0);
        chk("reset.StallCycles", bus.StallCycles, 0);
        chk("reset.FlushCount", bus.FlushCount, 0);
        @(posedge clk); #1;

        // Table
        resetDut();
        expStallCnt = 0; expFlushCnt = 0;
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            chkOut($sformatf("vec%0d", i), tbl[i].expStall, tbl[i].expFlush);
            if (tbl[i].expStall) expStallCnt++;
            if (tbl[i].expFlush) expFlushCnt++;
            @(posedge clk); #1;
        end
        chk("tbl.StallCycles", bus.StallCycles, 32'(expStallCnt));
        chk("tbl.FlushCount", bus.FlushCount, 32'(expFlushCnt));

        // lw $8 in EX, beq on $8: two stall cycles (RUN then HOLD), then resolves
        resetDut();
        v = ZV; v.br = 1; v.usesRs = 1; v.rs = 8; v.taken = 1; v.exWr = 1; v.exLd = 1; v.exAddr = 8;
        drive(v);
        @(negedge clk); chkOut("lw.c1", 1, 0);
        @(posedge clk); #1;
        v.exWr = 0; v.exLd = 0; v.exAddr = 0; v.memLd = 1; v.memAddr = 8; // HOLD ignores this
        drive(v);
        @(negedge clk); chkOut("lw.c2", 1, 0);
        chk("lw.c2.StallCycles", bus.StallCycles, 1);
        @(posedge clk); #1;
        v.memLd = 0; v.memAddr = 0;
        drive(v);
        @(negedge clk); chkOut("lw.c3", 0, 1);
        chk("lw.c3.StallCycles", bus.StallCycles, 2);
        @(posedge clk); #1;
        chk("lw.FlushCount", bus.FlushCount, 1);

        // add $9 in EX, bne on rt=$9: one stall then taken flush
        resetDut();
        v = ZV; v.br = 1; v.usesRt = 1; v.rt = 9; v.taken = 1; v.exWr = 1; v.exAddr = 9;
        drive(v);
        @(negedge clk); chkOut("add.c1", 1, 0);
        @(posedge clk); #1;
        v.exWr = 0; v.exAddr = 0;
        drive(v);
        @(negedge clk); chkOut("add.c2", 0, 1);
        @(posedge clk); #1;
        chk("add.StallCycles", bus.StallCycles, 1);
        chk("add.FlushCount", bus.FlushCount, 1);

        // Reset asserted while in HOLD
        resetDut();
        v = ZV; v.br = 1; v.usesRs = 1; v.rs = 8; v.exWr = 1; v.exLd = 1; v.exAddr = 8;
        drive(v);
        @(negedge clk); chkOut("rstHold.c1", 1, 0);
        @(posedge clk); #1;
        drive(ZV);
        #1 reset = 1'b1;
        #1;
        chkOut("rstHold.inReset", 0, 0);
        chk("rstHold.StallCycles", bus.StallCycles, 0);
        reset = 1'b0;
        @(negedge clk); chkOut("rstHold.after", 0, 0);
        @(posedge clk); #1;

        // Saturation on the 4-bit counter build
        resetDut();
        bus4.ID_UsesRs = 1; bus4.ID_RegRs = 10; bus4.EX_RegWrite = 1;
        bus4.EX_MemRead = 1; bus4.EX_RegWrAddr = 10;
        for (int i = 0; i < 14; i++) @(posedge clk);
        #1 chk("sat.14", bus4.StallCycles, 14);
        for (int i = 0; i < 6; i++) @(posedge clk);
        @(negedge clk);
        chk("sat.Stall", 32'(bus4.Stall), 1);
        chk("sat.20", bus4.StallCycles, 15);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
